// File: rtl/spi_frame_controller_if.sv
// spi_frame_controller_if
//   Bundles the frame request handshake and the SPI pins of spi_frame_controller.
//   master : the side that requests frames and plays the peripheral (drives start,
//            frame fields and cipo; observes ready, SPI outputs, rdata and done)
//   slave  : the controller itself
//   Signals:
//     start, ready             frame request handshake (accept on start && ready)
//     rw_in, addr_in, data_in  frame fields {rw, addr[6:0], data[7:0]}
//     sclk, copi, n_cs, cipo   SPI mode-0 link
//     rdata, done              readback byte and end-of-frame pulse
interface spi_frame_controller_if;
  logic       start;
  logic       ready;
  logic       rw_in;
  logic [6:0] addr_in;
  logic [7:0] data_in;
  logic       sclk;
  logic       copi;
  logic       n_cs;
  logic       cipo;
  logic [7:0] rdata;
  logic       done;

  modport master (
    output start, rw_in, addr_in, data_in, cipo,
    input  ready, sclk, copi, n_cs, rdata, done
  );

  modport slave (
    input  start, rw_in, addr_in, data_in, cipo,
    output ready, sclk, copi, n_cs, rdata, done
  );
endinterface

// File: rtl/spi_frame_controller.sv
// spi_frame_controller
//   SPI initiator for the 16-bit register frame {rw, addr[6:0], data[7:0]},
//   sent MSB first in mode 0 (sclk idles low, copi changes while sclk is low).
//   cipo is captured during the 8 data bits and presented on rdata at done.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    spi_frame_controller_if.slave (handshake, frame fields, SPI pins,
//            rdata, done)
//   Parameters: CLK_DIV (clk cycles per sclk half period), CS_SETUP, CS_HOLD,
//   IDLE_GAP (clk cycles for the respective n_cs phases).
module spi_frame_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_frame_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  // Phase counter is loaded with (length - 1) on entry, so a state lasts
  // exactly its parameter value in clk cycles.
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'(IDLE_GAP - 1);

  state_t      state;
  logic [7:0]  phase;
  logic [3:0]  bit_idx;
  logic [14:0] tx_shift;   // bits still to send after the one on copi
  logic [7:0]  rx_shift;
  logic        phase_end;

  assign phase_end = (phase == 8'd0);

  // Single FSM; every SPI pin and status output is a register so the link
  // never sees decode glitches. rw goes straight to copi on accept, the
  // remaining 15 bits wait in tx_shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 8'd0;
      bit_idx   <= 4'd15;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bus.sclk  <= 1'b0;
      bus.copi  <= 1'b0;
      bus.n_cs  <= 1'b1;
      bus.rdata <= '0;
      bus.done  <= 1'b0;
      bus.ready <= 1'b1;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tx_shift  <= {bus.addr_in, bus.data_in};
            bus.copi  <= bus.rw_in;
            bus.n_cs  <= 1'b0;
            bus.ready <= 1'b0;
            bit_idx   <= 4'd15;
            phase     <= SETUP_LD;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            phase <= DIV_LD;
            state <= LOW;
          end else begin
            phase <= phase - 8'd1;
          end
        end
        LOW: begin
          if (phase_end) begin
            bus.sclk <= 1'b1;
            phase    <= DIV_LD;
            state    <= HIGH;
          end else begin
            phase <= phase - 8'd1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            // Data bits are indices 7..0, i.e. bit_idx[3] clear.
            if (!bit_idx[3]) begin
              rx_shift <= {rx_shift[6:0], bus.cipo};
            end
            bus.sclk <= 1'b0;
            if (bit_idx == 4'd0) begin
              phase <= HOLD_LD;
              state <= HOLD;
            end else begin
              bit_idx  <= bit_idx - 4'd1;
              bus.copi <= tx_shift[14];
              tx_shift <= {tx_shift[13:0], 1'b0};
              phase    <= DIV_LD;
              state    <= LOW;
            end
          end else begin
            phase <= phase - 8'd1;
          end
        end
        HOLD: begin
          if (phase_end) begin
            bus.n_cs  <= 1'b1;
            bus.copi  <= 1'b0;
            bus.done  <= 1'b1;
            bus.rdata <= rx_shift;
            phase     <= GAP_LD;
            state     <= GAP;
          end else begin
            phase <= phase - 8'd1;
          end
        end
        GAP: begin
          if (phase_end) begin
            bus.ready <= 1'b1;
            phase     <= 8'd0;
            state     <= IDLE;
          end else begin
            phase <= phase - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_controller.sv
// tb_spi_frame_controller
//   Drives two controllers: dut_a with default timing (write/read/random,
//   back-to-back, busy start, mid-frame reset) and dut_b with CLK_DIV=2 decoded
//   by a behavioural peripheral deserializer. Expected frames, latencies and
//   readback bytes come from plain arithmetic on the frame rules.
module tb_spi_frame_controller;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int IDLE_GAP = 2;
  localparam int DIV_A    = 4;
  localparam int DIV_B    = 2;
  localparam int LAT_A    = 1 + CS_SETUP + 32 * DIV_A + CS_HOLD;
  localparam int LAT_B    = 1 + CS_SETUP + 32 * DIV_B + CS_HOLD;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_frame_controller_if bus_a ();
  spi_frame_controller_if bus_b ();

  spi_frame_controller #(
    .CLK_DIV (DIV_A), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .IDLE_GAP(IDLE_GAP)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  spi_frame_controller #(
    .CLK_DIV (DIV_B), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .IDLE_GAP(IDLE_GAP)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state for dut_a: queue of accepted frames, the peripheral's
  // reply word, and what the link actually carried.
  logic [15:0] exp_q[$];
  int          acc_q[$];
  logic [15:0] next_cipo = 16'h0;
  logic [15:0] cipo_word = 16'h0;
  logic [15:0] copi_seen = 16'h0;
  int          cipo_k    = 0;
  int          rises_a   = 0;
  int          done_cnt_a = 0;
  int          last_done_a = -1;
  bit          last_done_b2b = 1'b0;
  bit          b2b_mode  = 1'b0;
  int          glitch_a  = 0;
  logic        prev_sclk_a = 1'b0, prev_copi_a = 1'b0, prev_n_cs_a = 1'b1, prev_ready_a = 1'b1;

  always @(negedge clk) begin
    logic [15:0] f;
    int          a;
    if (rst_n) begin
      if (bus_a.start && bus_a.ready) begin
        exp_q.push_back({bus_a.rw_in, bus_a.addr_in, bus_a.data_in});
        acc_q.push_back(cyc);
      end
      if (prev_n_cs_a && !bus_a.n_cs) begin
        // n_cs stays high for the GAP cycles plus the IDLE cycle that accepts.
        if (b2b_mode && last_done_b2b)
          check_output("ncs_high_gap", cyc - last_done_a, IDLE_GAP + 1);
        cipo_word  = next_cipo;
        cipo_k     = 0;
        bus_a.cipo = cipo_word[15];
        copi_seen  = 16'h0;
        rises_a    = 0;
      end
      if (!prev_sclk_a && bus_a.sclk) begin
        copi_seen = {copi_seen[14:0], bus_a.copi};
        rises_a++;
      end
      if (prev_sclk_a && !bus_a.sclk && !bus_a.n_cs) begin
        cipo_k++;
        if (cipo_k < 16) bus_a.cipo = cipo_word[15 - cipo_k];
      end
      if (prev_sclk_a && bus_a.sclk && (bus_a.copi !== prev_copi_a)) glitch_a++;
      if (prev_n_cs_a && bus_a.n_cs && (bus_a.sclk !== prev_sclk_a)) glitch_a++;
      if (bus_a.done) begin
        done_cnt_a++;
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          f = exp_q.pop_front();
          a = acc_q.pop_front();
          check_output("frame_bits", copi_seen, f);
          check_output("rise_count", rises_a, 16);
          check_output("done_latency", cyc - a, LAT_A);
          check_output("rdata", bus_a.rdata, cipo_word[7:0]);
          check_output("ncs_at_done", bus_a.n_cs, 1);
        end
        last_done_a   = cyc;
        last_done_b2b = b2b_mode;
      end
      if (bus_a.ready && !prev_ready_a && last_done_a >= 0)
        check_output("ready_after_done", cyc - last_done_a, IDLE_GAP);
    end else begin
      exp_q.delete();
      acc_q.delete();
    end
    prev_sclk_a  = bus_a.sclk;
    prev_copi_a  = bus_a.copi;
    prev_n_cs_a  = bus_a.n_cs;
    prev_ready_a = bus_a.ready;
  end

  // Behavioural peripheral deserializer on dut_b: samples copi on sclk rise,
  // decodes the frame at done and measures every complete sclk half period.
  logic [15:0] exp_b   = 16'h0;
  logic [15:0] frame_b = 16'h0;
  int          rises_b = 0, run_b = 0, acc_b = -1, done_cnt_b = 0;
  bit          fell_b  = 1'b0;
  logic        prev_sclk_b = 1'b0, prev_n_cs_b = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.start && bus_b.ready) acc_b = cyc;
      if (prev_n_cs_b && !bus_b.n_cs) begin
        frame_b = 16'h0;
        rises_b = 0;
        fell_b  = 1'b0;
      end
      if (!bus_b.n_cs && (bus_b.sclk !== prev_sclk_b)) begin
        if (bus_b.sclk) begin
          frame_b = {frame_b[14:0], bus_b.copi};
          rises_b++;
          if (fell_b) check_output("b_sclk_low", run_b, DIV_B);
        end else begin
          check_output("b_sclk_high", run_b, DIV_B);
          fell_b = 1'b1;
        end
        run_b = 1;
      end else begin
        run_b++;
      end
      if (bus_b.done) begin
        done_cnt_b++;
        check_output("b_rw", frame_b[15], exp_b[15]);
        check_output("b_addr", frame_b[14:8], exp_b[14:8]);
        check_output("b_data", frame_b[7:0], exp_b[7:0]);
        check_output("b_valid", rises_b, 16);
        check_output("b_latency", cyc - acc_b, LAT_B);
      end
    end
    prev_sclk_b = bus_b.sclk;
    prev_n_cs_b = bus_b.n_cs;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit on_b, input int limit);
    int n = 0;
    while (!(on_b ? bus_b.ready : bus_a.ready) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output(on_b ? "b_ready_wait" : "ready_wait", on_b ? bus_b.ready : bus_a.ready, 1);
  endtask

  task automatic wait_rises(input int n, input int limit);
    int k = 0;
    while (rises_a < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_output("rise_wait", rises_a >= n, 1);
  endtask

  // One frame request on dut_a; inputs are scrambled right after accept.
  task automatic apply_stimulus(input logic rw, input logic [6:0] addr,
                                input logic [7:0] data);
    wait_ready(1'b0, 400);
    tick();
    bus_a.start   = 1'b1;
    bus_a.rw_in   = rw;
    bus_a.addr_in = addr;
    bus_a.data_in = data;
    tick();
    bus_a.start   = 1'b0;
    bus_a.rw_in   = 1'($urandom);
    bus_a.addr_in = 7'($urandom);
    bus_a.data_in = 8'($urandom);
    tick();
  endtask

  initial begin
    int base;
    int n;
    bus_a.start = 1'b0; bus_a.rw_in = 1'b0; bus_a.addr_in = '0; bus_a.data_in = '0;
    bus_b.start = 1'b0; bus_b.rw_in = 1'b0; bus_b.addr_in = '0; bus_b.data_in = '0;
    bus_b.cipo  = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) tick();
    check_output("rst_n_cs", bus_a.n_cs, 1);
    check_output("rst_sclk", bus_a.sclk, 0);
    check_output("rst_copi", bus_a.copi, 0);
    check_output("rst_rdata", bus_a.rdata, 0);
    check_output("rst_done", bus_a.done, 0);
    check_output("rst_ready", bus_a.ready, 1);
    rst_n = 1'b1;
    tick();

    $display("[TB] write frame 2A/C3");
    next_cipo = 16'($urandom);
    apply_stimulus(1'b1, 7'h2A, 8'hC3);
    wait_ready(1'b0, 400);

    $display("[TB] read frame addr 05 with reply A5");
    next_cipo = {8'($urandom), 8'hA5};
    apply_stimulus(1'b0, 7'h05, 8'($urandom));
    wait_ready(1'b0, 400);
    check_output("read_rdata", bus_a.rdata, 8'hA5);

    $display("[TB] random frames");
    for (int i = 0; i < 4; i++) begin
      next_cipo = 16'($urandom);
      apply_stimulus(1'($urandom), 7'($urandom), 8'($urandom));
      wait_ready(1'b0, 400);
    end

    $display("[TB] start held high");
    base     = done_cnt_a;
    b2b_mode = 1'b1;
    tick();
    bus_a.start = 1'b1;
    n = 0;
    while (done_cnt_a < base + 3 && n < 1000) begin
      bus_a.rw_in   = 1'($urandom);
      bus_a.addr_in = 7'($urandom);
      bus_a.data_in = 8'($urandom);
      next_cipo     = 16'($urandom);
      tick();
      n++;
    end
    bus_a.start = 1'b0;
    check_output("b2b_frames", done_cnt_a - base, 3);
    wait_ready(1'b0, 400);
    tick();
    b2b_mode = 1'b0;

    $display("[TB] start pulsed while busy");
    base = done_cnt_a;
    apply_stimulus(1'b1, 7'($urandom), 8'($urandom));
    wait_rises(5, 200);
    tick();
    bus_a.start   = 1'b1;
    bus_a.rw_in   = 1'b0;
    bus_a.addr_in = 7'($urandom);
    bus_a.data_in = 8'($urandom);
    tick();
    bus_a.start = 1'b0;
    wait_ready(1'b0, 400);
    repeat (10) tick();
    check_output("busy_one_done", done_cnt_a - base, 1);

    $display("[TB] reset during bit 9");
    base = done_cnt_a;
    apply_stimulus(1'b1, 7'($urandom), 8'($urandom));
    wait_rises(7, 200);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_n_cs", bus_a.n_cs, 1);
    check_output("midrst_sclk", bus_a.sclk, 0);
    check_output("midrst_ready", bus_a.ready, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_output("midrst_no_done", done_cnt_a - base, 0);
    check_output("midrst_rdata", bus_a.rdata, 0);
    next_cipo = 16'($urandom);
    apply_stimulus(1'b1, 7'h00, 8'h7F);
    wait_ready(1'b0, 400);

    $display("[TB] CLK_DIV=2 loopback");
    for (int i = 0; i < 2; i++) begin
      base = done_cnt_b;
      wait_ready(1'b1, 400);
      tick();
      exp_b = (i == 0) ? 16'h913C : 16'($urandom);
      bus_b.start   = 1'b1;
      bus_b.rw_in   = exp_b[15];
      bus_b.addr_in = exp_b[14:8];
      bus_b.data_in = exp_b[7:0];
      tick();
      bus_b.start   = 1'b0;
      bus_b.addr_in = 7'($urandom);
      tick();
      wait_ready(1'b1, 400);
      check_output("b_done_count", done_cnt_b - base, 1);
    end

    check_output("glitch_a", glitch_a, 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
